// File: rtl/eq_spi_tx.sv
// SPI mode-0 peripheral transmitter: returns WIDTH-bit status words to the MCU on sdo.
// A single-word holding buffer with a valid/ready handshake decouples the producer from frame timing.
`timescale 1ns/1ps
module eq_spi_tx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             realReset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             sck,
    input  logic             ce,
    output logic             sdo,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun,
    output logic             abort
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [SYNC_STAGES-1:0] sck_sync_reg, ce_sync_reg;
    logic                   sck_hist_reg, ce_hist_reg;
    logic [WIDTH-1:0]       shift_reg, shift_next;
    logic [WIDTH-1:0]       hold_reg, hold_next;
    logic                   hold_full_reg, hold_full_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   frame_done_reg, frame_done_next;
    logic                   underrun_reg, underrun_next;
    logic                   abort_reg, abort_next;

    logic sck_s, ce_s, sck_rise, sck_fall, ce_rise, ce_fall, accept;

    // Edges compare the last synchronizer stage against one extra history flop.
    assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
    assign ce_s     = ce_sync_reg[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist_reg;
    assign sck_fall = ~sck_s & sck_hist_reg;
    assign ce_rise  = ce_s & ~ce_hist_reg;
    assign ce_fall  = ~ce_s & ce_hist_reg;
    assign accept   = tx_valid & ~hold_full_reg;

    always_ff @(posedge clk or posedge realReset) begin
        if (realReset) begin
            state_reg      <= IDLE;
            sck_sync_reg   <= '0;
            ce_sync_reg    <= '0;
            sck_hist_reg   <= 1'b0;
            ce_hist_reg    <= 1'b0;
            shift_reg      <= '0;
            hold_reg       <= '0;
            hold_full_reg  <= 1'b0;
            cnt_reg        <= '0;
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
            abort_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sck_sync_reg   <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
            ce_sync_reg    <= {ce_sync_reg[SYNC_STAGES-2:0], ce};
            sck_hist_reg   <= sck_s;
            ce_hist_reg    <= ce_s;
            shift_reg      <= shift_next;
            hold_reg       <= hold_next;
            hold_full_reg  <= hold_full_next;
            cnt_reg        <= cnt_next;
            frame_done_reg <= frame_done_next;
            underrun_reg   <= underrun_next;
            abort_reg      <= abort_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        hold_next       = hold_reg;
        hold_full_next  = hold_full_reg;
        cnt_next        = cnt_reg;
        frame_done_next = 1'b0;
        underrun_next   = 1'b0;
        abort_next      = 1'b0;

        // An accept only happens while empty, so it never collides with a frame consuming the buffer.
        if (accept) begin
            hold_next      = tx_data;
            hold_full_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (ce_rise) begin
                    if (hold_full_reg) begin
                        shift_next     = hold_reg;
                        hold_full_next = 1'b0;
                    end else begin
                        shift_next    = '0;
                        underrun_next = 1'b1;
                    end
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (ce_fall) begin
                    abort_next = 1'b1;
                    state_next = IDLE;
                end else if (sck_rise) begin
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        frame_done_next = 1'b1;
                        state_next      = DONE;
                    end
                end else if (sck_fall && (cnt_reg < CW'(WIDTH))) begin
                    shift_next = {shift_reg[WIDTH-2:0], 1'b0};
                end
            end
            DONE: begin
                if (ce_fall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy       = (state_reg == SHIFT);
    assign sdo        = busy & shift_reg[WIDTH-1];
    assign tx_ready   = ~hold_full_reg;
    assign frame_done = frame_done_reg;
    assign underrun   = underrun_reg;
    assign abort      = abort_reg;
endmodule

// File: tb/tb_eq_spi_tx.sv
// Scoreboarded bench for eq_spi_tx: an MCU model clocks frames out while a monitor
// checks each completed or aborted frame against a queue-based model of the holding buffer.
`timescale 1ns/1ps
module tb_eq_spi_tx;
    logic        clk = 1'b0;
    logic        realReset;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        sck = 1'b0;
    logic        ce = 1'b0;
    logic        sdo, busy, frame_done, underrun, abort;

    eq_spi_tx #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .realReset(realReset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .sck(sck), .ce(ce), .sdo(sdo), .busy(busy),
        .frame_done(frame_done), .underrun(underrun), .abort(abort)
    );

    always #42 clk = ~clk;  // ~12 MHz

    typedef struct {
        logic [31:0] word;
        logic        un;
        logic        ab;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] buf_q[$];   // model of the one-word holding buffer
    logic [31:0] rx_word;    // what the MCU shifted in
    int          un_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          frame_no = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every frame_done/abort pulse retires the oldest expected frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (underrun) un_cnt++;
            if (frame_done || abort) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_end", {31'd0, abort}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("end_is_abort", {31'd0, abort}, {31'd0, e.ab});
                    check("underrun_pulses", 32'(un_cnt), {31'd0, e.un});
                    if (!abort) check("rx_word", rx_word, e.word);
                    $display("frame %0d: %s rx=%h exp=%h underrun=%0d", frame_no,
                             abort ? "abort" : "done", rx_word, e.word, un_cnt);
                end
                frame_no++;
                un_cnt = 0;
            end
        end
    end

    task automatic write_word(input logic [31:0] w);
        bit done = 0;
        @(posedge clk); #1;
        tx_data  = w;
        tx_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (tx_ready) begin
                @(posedge clk); #1;
                tx_valid = 1'b0;
                buf_q.push_back(w);
                check("tx_ready_after_write", {31'd0, tx_ready}, 32'd0);
                done = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            tx_valid = 1'b0;
            check("write_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic run_frame(input int nbits, input bit mid_wr, input logic [31:0] mid_w,
                             input bit sim_wr, input logic [31:0] sim_w, input bit do_rst);
        exp_t e;
        bit   was_empty;
        @(posedge clk); #1;
        ce = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // The synced ce rise takes effect on the next edge; present a word on that same edge.
        if (sim_wr) begin
            tx_data  = sim_w;
            tx_valid = 1'b1;
        end
        @(posedge clk); #1;
        tx_valid  = 1'b0;
        was_empty = (buf_q.size() == 0);
        if (!was_empty) begin
            e.word = buf_q.pop_front();
            e.un   = 1'b0;
        end else begin
            e.word = '0;
            e.un   = 1'b1;
        end
        e.ab = (nbits < 32);
        if (sim_wr && was_empty) buf_q.push_back(sim_w);
        if (!do_rst) exp_q.push_back(e);
        #400;
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        check("tx_ready_at_start", {31'd0, tx_ready}, {31'd0, buf_q.size() == 0});
        rx_word = '0;
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b1;
            rx_word = {rx_word[30:0], sdo};
            #500;
            sck = 1'b0;
            #500;
            if (mid_wr && i == 3) write_word(mid_w);
        end
        if (do_rst) begin
            realReset = 1'b1;
            #1;
            check("rst_sdo", {31'd0, sdo}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
            ce = 1'b0;
            buf_q.delete();
            #300;
            realReset = 1'b0;
            un_cnt = 0;
            #300;
        end else begin
            ce = 1'b0;
            #800;
        end
    endtask

    initial begin
        int nb;
        bit mw;
        realReset = 1'b1;
        #100;
        check("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_sdo", {31'd0, sdo}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_pulses", {29'd0, frame_done, underrun, abort}, 32'd0);
        @(negedge clk);
        realReset = 1'b0;
        #200;

        write_word(32'h1234_5678);
        run_frame(32, 0, '0, 0, '0, 0);

        write_word(32'hA5A5_A5A5);
        run_frame(32, 1, 32'h0F0F_0F0F, 0, '0, 0);
        run_frame(32, 0, '0, 0, '0, 0);

        run_frame(32, 0, '0, 0, '0, 0);

        write_word(32'hDEAD_BEEF);
        run_frame(10, 0, '0, 0, '0, 0);
        write_word(32'h1111_2222);
        run_frame(32, 0, '0, 0, '0, 0);

        write_word(32'hCAFE_F00D);
        run_frame(5, 0, '0, 0, '0, 1);
        run_frame(32, 0, '0, 0, '0, 0);

        run_frame(32, 0, '0, 1, 32'h55AA_55AA, 0);
        run_frame(32, 0, '0, 0, '0, 0);

        for (int r = 0; r < 10; r++) begin
            if (buf_q.size() == 0 && $urandom_range(0, 3) != 0) write_word($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 32;
            mw = (nb > 4) && ($urandom_range(0, 1) == 1);
            run_frame(nb, mw, $urandom, 0, '0, 0);
        end

        #1000;
        check("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
